fifo_wr_arb: RTL and testbench

//  Shares one FIFO write port among N_REQ requesters using round-robin arbitration.

---
 rtl/fifo_wr_arb.sv | 96 +++++++++
 tb/tb_fifo_wr_arb.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready requesters.
// Multi-beat packets hold the port until the beat carrying req_last_i is accepted.
module fifo_wr_arb #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ-1:0]            req_last_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  logic                        fifo_full_i,
  output logic                        fifo_wr_o,
  output logic [DATA_WIDTH-1:0]       fifo_wdata_o,
  output logic [N_REQ-1:0]            grant_o,
  output logic                        locked_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               beat;
  logic               beat_last;
  int                 cand;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
  endfunction

  // Scan from the lowest priority upward so the requester closest to rr_ptr wins last.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    if (state_q == LOCKED) begin
      grant_idx = owner_q;
      grant_any = 1'b1;
    end else begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        cand = (int'(rr_ptr_q) + i) % N_REQ;
        if (req_valid_i[cand]) begin
          grant_idx = cand[IDX_W-1:0];
          grant_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_o = '0;
    if (grant_any) grant_o[grant_idx] = 1'b1;
  end

  assign req_ready_o  = grant_o & {N_REQ{~fifo_full_i}};
  assign beat         = grant_any & req_valid_i[grant_idx] & ~fifo_full_i;
  assign beat_last    = req_last_i[grant_idx];
  assign fifo_wr_o    = beat;
  assign fifo_wdata_o = grant_any ? req_data_i[grant_idx*DATA_WIDTH +: DATA_WIDTH]
                                  : '0;
  assign locked_o     = (state_q == LOCKED);

  // Priority advances only at packet end, bounding each requester's wait to N_REQ-1 packets.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else if (beat) begin
      case (state_q)
        IDLE: begin
          if (beat_last) begin
            rr_ptr_q <= next_idx(grant_idx);
          end else begin
            state_q <= LOCKED;
            owner_q <= grant_idx;
          end
        end
        LOCKED: begin
          if (beat_last) begin
            state_q  <= IDLE;
            rr_ptr_q <= next_idx(owner_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: round-robin order, packet lock, stalls, full, reset.
module tb_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr;
  logic [DW-1:0]   fifo_wdata;
  logic [N-1:0]    grant;
  logic            locked;

  int n_checks = 0;
  int n_err    = 0;

  fifo_wr_arb #(.N_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid),
    .req_last_i   (req_last),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .fifo_full_i  (fifo_full),
    .fifo_wr_o    (fifo_wr),
    .fifo_wdata_o (fifo_wdata),
    .grant_o      (grant),
    .locked_o     (locked)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setr(input int k, input logic v, input logic l, input logic [DW-1:0] d);
    req_valid[k]          = v;
    req_last[k]           = l;
    req_data[k*DW +: DW]  = d;
  endtask

  task automatic clr_all();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Checks grant, write strobe, data and lock for the current cycle.
  task automatic chk_cyc(input string tag, input logic [N-1:0] g, input logic wr,
                         input logic [DW-1:0] wd, input logic lk);
    chk({tag, ".grant"},  32'(grant),   32'(g));
    chk({tag, ".wr"},     32'(fifo_wr), 32'(wr));
    if (wr) chk({tag, ".wdata"}, 32'(fifo_wdata), 32'(wd));
    chk({tag, ".locked"}, 32'(locked),  32'(lk));
  endtask

  initial begin
    rst_ni    = 1'b0;
    fifo_full = 1'b0;
    clr_all();

    // Reset with no requests: everything quiet
    #3;
    chk("rst.grant",  32'(grant),      32'h0);
    chk("rst.wr",     32'(fifo_wr),    32'h0);
    chk("rst.locked", 32'(locked),     32'h0);
    chk("rst.ready",  32'(req_ready),  32'h0);
    chk("rst.wdata",  32'(fifo_wdata), 32'h0);
    rst_ni = 1'b1;
    tick();

    // Requesters 0 and 2 with back-to-back single-beat packets alternate
    for (int i = 0; i < 4; i++) begin
      setr(0, 1'b1, 1'b1, 8'h10 + 8'(i));
      setr(2, 1'b1, 1'b1, 8'h20 + 8'(i));
      #1;
      if (i % 2 == 0) chk_cyc("alt", 4'b0001, 1'b1, 8'h10 + 8'(i), 1'b0);
      else            chk_cyc("alt", 4'b0100, 1'b1, 8'h20 + 8'(i), 1'b0);
      chk("alt.ready", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h4);
      tick();
    end
    clr_all();

    // rr_ptr is 3: one packet from requester 0 moves it to 1
    setr(0, 1'b1, 1'b1, 8'h5A);
    #1;
    chk_cyc("pre3", 4'b0001, 1'b1, 8'h5A, 1'b0);
    tick();
    clr_all();

    // 3-beat packet from requester 1 while requester 3 waits
    setr(1, 1'b1, 1'b0, 8'hAA);
    setr(3, 1'b1, 1'b1, 8'h33);
    #1;
    chk_cyc("pktA", 4'b0010, 1'b1, 8'hAA, 1'b0);
    tick();
    setr(1, 1'b1, 1'b0, 8'hBB);
    #1;
    chk_cyc("pktB", 4'b0010, 1'b1, 8'hBB, 1'b1);
    chk("pktB.ready", 32'(req_ready), 32'h2);
    tick();

    // Owner stalls for two cycles: no writes, lock and grant held
    for (int i = 0; i < 2; i++) begin
      setr(1, 1'b0, 1'b0, 8'h00);
      #1;
      chk_cyc("stall", 4'b0010, 1'b0, 8'h00, 1'b1);
      tick();
    end
    setr(1, 1'b1, 1'b1, 8'hCC);
    #1;
    chk_cyc("pktC", 4'b0010, 1'b1, 8'hCC, 1'b1);
    tick();
    setr(1, 1'b0, 1'b0, 8'h00);
    #1;
    chk_cyc("r3next", 4'b1000, 1'b1, 8'h33, 1'b0);
    tick();
    clr_all();

    // FIFO full for 4 cycles; higher-priority requester 0 arrives during full and wins
    fifo_full = 1'b1;
    setr(2, 1'b1, 1'b1, 8'h55);
    #1;
    chk_cyc("full1", 4'b0100, 1'b0, 8'h00, 1'b0);
    chk("full1.ready", 32'(req_ready), 32'h0);
    chk("full1.wdata", 32'(fifo_wdata), 32'h55);
    tick();
    setr(0, 1'b1, 1'b1, 8'h66);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_cyc("fullN", 4'b0001, 1'b0, 8'h00, 1'b0);
      chk("fullN.ready", 32'(req_ready), 32'h0);
      tick();
    end
    fifo_full = 1'b0;
    #1;
    chk_cyc("unfull0", 4'b0001, 1'b1, 8'h66, 1'b0);
    tick();
    setr(0, 1'b0, 1'b0, 8'h00);
    #1;
    chk_cyc("unfull2", 4'b0100, 1'b1, 8'h55, 1'b0);
    tick();
    setr(2, 1'b0, 1'b0, 8'h00);
    #1;
    chk_cyc("drained", 4'b0000, 1'b0, 8'h00, 1'b0);

    // rr_ptr is 3: a packet from requester 3 wraps it to 0
    setr(3, 1'b1, 1'b1, 8'h77);
    #1;
    chk_cyc("wrap3", 4'b1000, 1'b1, 8'h77, 1'b0);
    tick();

    // All four valid: order 0,1,2,3,0
    for (int k = 0; k < N; k++) setr(k, 1'b1, 1'b1, 8'h40 + 8'(k));
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_cyc("rr", 4'(1 << (i % N)), 1'b1, 8'h40 + 8'(i % N), 1'b0);
      tick();
    end
    clr_all();

    // rr_ptr is 1: requester 2 opens a packet, then reset lands mid-packet
    setr(2, 1'b1, 1'b0, 8'h99);
    #1;
    chk_cyc("lockR", 4'b0100, 1'b1, 8'h99, 1'b0);
    tick();
    chk("lockR.locked", 32'(locked), 32'h1);
    for (int k = 0; k < N; k++) setr(k, 1'b1, 1'b1, 8'h80 + 8'(k));
    rst_ni = 1'b0;
    #1;
    chk_cyc("inrst", 4'b0001, 1'b1, 8'h80, 1'b0);
    rst_ni = 1'b1;
    #1;
    chk_cyc("postrst", 4'b0001, 1'b1, 8'h80, 1'b0);
    tick();
    #1;
    chk_cyc("postrst2", 4'b0010, 1'b1, 8'h81, 1'b0);
    clr_all();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
